score_digit_scanner: RTL and testbench
======================================

Name: score_digit_scanner

Overview:
- 4-digit BCD distance/score counter with time-multiplexed digit scan for the common-anode 7-segment display.
- Emits one BCD digit per scan slot on digit_bcd, which feeds the downstream binary_to_segment decoder, and the matching active-low anode select.
- Sits between the game-logic distance tick and the segment decoder.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit slot is held (1 kHz digit rate at 50 MHz); legal range 2..2^20.
- BLANK_LZ, 1, 1 = suppress leading-zero digits; 0 = always show all four digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inc  in  1  one-cycle pulse; add 1 to score.
- clear  in  1  synchronous clear of score and sat.
- freeze  in  1  1 = ignore inc (game over / pause); scan continues.
- digit_bcd  out  4  BCD value of the currently scanned digit, 0..9.
- anode  out  4  active-low digit enable; anode[0] = ones digit, anode[3] = thousands digit.
- score_bcd  out  16  full score as {thousands, hundreds, tens, ones}.
- sat  out  1  sticky flag; 1 once score reaches 9999.

Behaviour:
- Reset (rst_n low, asynchronous):
  - score_bcd = 16'h0000, sat = 0, scan index = 0, scan counter = 0.
  - Outputs during reset: digit_bcd = 0, anode = 4'b1110.
- Score update, evaluated each rising edge in priority order:
  - 1. clear: score = 0000, sat = 0.
  - 2. freeze or sat: hold.
  - 3. inc: BCD increment with full ripple carry completed in one cycle (0099 -> 0100, 0999 -> 1000).
  - 4. otherwise hold.
  - No digit ever holds a value above 9.
- Saturation: an inc that produces 9999 sets sat on the same edge. Further inc pulses are ignored and the score never wraps to 0000. Only clear or reset releases sat.
- Latency: score_bcd and digit_bcd reflect an inc on the edge that samples it, i.e. visible the next cycle.
- Scan timing:
  - Scan counter counts 0..SCAN_DIV-1.
  - On the edge where the counter equals SCAN_DIV-1, the counter returns to 0 and the scan index advances 0 -> 1 -> 2 -> 3 -> 0.
  - Each slot therefore lasts exactly SCAN_DIV cycles.
  - clear and freeze do not affect the scan.
- Output decode:
  - digit_bcd and anode are combinational from the registered scan index and score_bcd.
  - digit_bcd = score_bcd[4*idx+3 : 4*idx].
  - anode = all ones except bit idx, which is 0.
- Leading-zero blanking (BLANK_LZ = 1):
  - Digit k (k ≥ 1) is blanked when digits k..3 are all zero.
  - When blanked, anode = 4'b1111 for that slot and digit_bcd = 0.
  - Digit 0 is never blanked, so score 0000 displays a single "0".
- Simultaneous events:
  - clear together with inc: clear wins and the result is 0000.
  - inc arriving at a scan-slot boundary: both take effect on the same edge; the new slot shows the updated score.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge. Scanning resumes from slot 0 on the first clk edge after rst_n deasserts.

Test Plan:
- Reset, then SCAN_DIV = 4 with no inc -> anode cycles 1110, 1111, 1111, 1111 (leading zeros blanked), 4 cycles per slot, repeating; digit_bcd = 0 throughout.
- 42 inc pulses, BLANK_LZ = 1 -> score_bcd = 0042; slots show anode/digit 1110/2, 1101/4, 1111/0, 1111/0. With BLANK_LZ = 0, the slots show 1011/0 and 0111/0 instead of the blanked slots.
- Preload to 0999 via inc pulses, then one inc -> score_bcd = 16'h1000 on the next cycle, sat = 0.
- Drive 9999 increments, then 3 more -> score_bcd holds 16'h9999 and sat = 1. Then assert clear with inc high -> score_bcd = 0000, sat = 0.
- freeze = 1 during 5 inc pulses -> score unchanged and scan continues. Deassert freeze, apply 1 inc -> score +1.
- Assert rst_n low mid-slot 2 at score 0123, between clock edges -> outputs immediately show score 0000, anode = 1110, sat = 0. After release, a full slot of SCAN_DIV cycles precedes the move to slot 1.

Source files
------------

// File: rtl/score_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : score_digit_scanner
// Purpose  : 4-digit BCD score counter with time-multiplexed 7-segment scan.
// Revision : 1.0  initial release
// ============================================================================
module score_digit_scanner #(
   parameter int SCAN_DIV = 50000,
   parameter int BLANK_LZ = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   input  logic        clear,
   input  logic        freeze,
   output logic [3:0]  digit_bcd,
   output logic [3:0]  anode,
   output logic [15:0] score_bcd,
   output logic        sat
);

   localparam int                 c_CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCAN_DIV - 1);

   logic [15:0]        r_score;
   logic               r_sat;
   logic [c_CNT_W-1:0] r_cnt;
   logic [1:0]         r_idx;

   logic [15:0]        w_score_inc;
   logic               w_carry;
   logic [3:0]         w_blank;
   logic [3:0]         w_digit;

   // Ripple carry across all four digits settles within one cycle.
   always_comb begin
      w_score_inc = r_score;
      w_carry     = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (w_carry) begin
            if (r_score[4*k +: 4] == 4'd9) begin
               w_score_inc[4*k +: 4] = 4'd0;
            end else begin
               w_score_inc[4*k +: 4] = r_score[4*k +: 4] + 4'd1;
               w_carry               = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_score <= 16'h0000;
         r_sat   <= 1'b0;
      end else if (clear) begin
         r_score <= 16'h0000;
         r_sat   <= 1'b0;
      end else if (freeze || r_sat) begin
         r_score <= r_score;
         r_sat   <= r_sat;
      end else if (inc) begin
         r_score <= w_score_inc;
         r_sat   <= (w_score_inc == 16'h9999);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= 2'd0;
      end else if (r_cnt == c_CNT_LAST) begin
         r_cnt <= '0;
         r_idx <= r_idx + 2'd1;
      end else begin
         r_cnt <= r_cnt + c_CNT_W'(1);
      end
   end

   // Digit k is a leading zero when it and every more significant digit are zero.
   assign w_blank[0] = 1'b0;
   generate
      for (genvar k = 1; k < 4; k++) begin : g_blank
         assign w_blank[k] = (BLANK_LZ != 0) && (r_score[15:4*k] == '0);
      end
   endgenerate

   always_comb begin
      w_digit = r_score[3:0];
      case (r_idx)
         2'd0:    w_digit = r_score[3:0];
         2'd1:    w_digit = r_score[7:4];
         2'd2:    w_digit = r_score[11:8];
         default: w_digit = r_score[15:12];
      endcase
   end

   assign digit_bcd = w_blank[r_idx] ? 4'd0    : w_digit;
   assign anode     = w_blank[r_idx] ? 4'b1111 : ~(4'b0001 << r_idx);
   assign score_bcd = r_score;
   assign sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_score_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_digit_scanner
// Purpose  : Directed self-checking bench; blanking and non-blanking instances.
// Revision : 1.0  initial release
// ============================================================================
module tb_score_digit_scanner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inc = 1'b0;
   logic        clear = 1'b0;
   logic        freeze = 1'b0;

   logic [3:0]  digit_bl, anode_bl, digit_nb, anode_nb;
   logic [15:0] score_bl, score_nb;
   logic        sat_bl, sat_nb;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   score_digit_scanner #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
      .clk(clk), .rst_n(rst_n), .inc(inc), .clear(clear), .freeze(freeze),
      .digit_bcd(digit_bl), .anode(anode_bl), .score_bcd(score_bl), .sat(sat_bl)
   );

   score_digit_scanner #(.SCAN_DIV(4), .BLANK_LZ(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .inc(inc), .clear(clear), .freeze(freeze),
      .digit_bcd(digit_nb), .anode(anode_nb), .score_bcd(score_nb), .sat(sat_nb)
   );

   typedef struct {
      logic        inc;
      logic        clr;
      logic        frz;
      logic [15:0] score;
      logic        sat;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic inc_n(input int n);
      inc = 1'b1;
      repeat (n) tick();
      inc = 1'b0;
   endtask

   task automatic wait_nb_anode(input logic [3:0] a, input string name);
      int n;
      n = 0;
      while (anode_nb !== a && n < 40) begin
         tick();
         n++;
      end
      chk(name, {28'd0, anode_nb}, {28'd0, a});
   endtask

   task automatic chk_slot(input string name, input logic [3:0] an_bl, input logic [3:0] d_bl,
                           input logic [3:0] an_nb, input logic [3:0] d_nb);
      chk({name, "_anode_bl"}, {28'd0, anode_bl}, {28'd0, an_bl});
      chk({name, "_digit_bl"}, {28'd0, digit_bl}, {28'd0, d_bl});
      chk({name, "_anode_nb"}, {28'd0, anode_nb}, {28'd0, an_nb});
      chk({name, "_digit_nb"}, {28'd0, digit_nb}, {28'd0, d_nb});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] an_before;
      int         slot;

      // inc clr frz -> score sat
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0002, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0002, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h0002, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0003, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0002, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};

      #1;
      chk("rst_score", {16'd0, score_bl}, 32'h0000);
      chk("rst_sat", {31'd0, sat_bl}, 32'd0);
      chk("rst_anode", {28'd0, anode_bl}, 32'hE);
      chk("rst_digit", {28'd0, digit_bl}, 32'h0);

      // Idle scan from reset release: slot = (edges/4) % 4.
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 16; n++) begin
         slot = (n / 4) % 4;
         chk($sformatf("scan_nb_%0d", n), {28'd0, anode_nb}, {28'd0, ~(4'b0001 << slot)});
         chk($sformatf("scan_bl_%0d", n), {28'd0, anode_bl}, (slot == 0) ? 32'hE : 32'hF);
         chk($sformatf("scan_dg_%0d", n), {28'd0, digit_bl}, 32'h0);
         tick();
      end

      for (int i = 0; i < 12; i++) begin
         inc = vecs[i].inc; clear = vecs[i].clr; freeze = vecs[i].frz;
         tick();
         chk($sformatf("vec%0d_score", i), {16'd0, score_bl}, {16'd0, vecs[i].score});
         chk($sformatf("vec%0d_sat", i), {31'd0, sat_bl}, {31'd0, vecs[i].sat});
      end
      inc = 1'b0; clear = 1'b0; freeze = 1'b0;

      // 42 increments, both blanking modes.
      inc_n(42);
      chk("s42_score", {16'd0, score_bl}, 32'h0042);
      wait_nb_anode(4'b1110, "s42_align");
      chk_slot("s42_slot0", 4'b1110, 4'd2, 4'b1110, 4'd2);
      repeat (4) tick();
      chk_slot("s42_slot1", 4'b1101, 4'd4, 4'b1101, 4'd4);
      repeat (4) tick();
      chk_slot("s42_slot2", 4'b1111, 4'd0, 4'b1011, 4'd0);
      repeat (4) tick();
      chk_slot("s42_slot3", 4'b1111, 4'd0, 4'b0111, 4'd0);

      // 0099 -> 0100 landing exactly on the slot1->slot2 boundary.
      clear = 1'b1; tick(); clear = 1'b0;
      inc_n(99);
      chk("s99_score", {16'd0, score_bl}, 32'h0099);
      wait_nb_anode(4'b1110, "s99_align0");
      wait_nb_anode(4'b1101, "s99_align1");
      repeat (3) tick();
      inc = 1'b1; tick(); inc = 1'b0;
      chk("s100_score", {16'd0, score_bl}, 32'h0100);
      chk_slot("s100_slot2", 4'b1011, 4'd1, 4'b1011, 4'd1);

      inc_n(899);
      chk("s999_score", {16'd0, score_bl}, 32'h0999);
      inc_n(1);
      chk("s1000_score", {16'd0, score_bl}, 32'h1000);
      chk("s1000_sat", {31'd0, sat_bl}, 32'd0);

      // Saturation at 9999.
      clear = 1'b1; tick(); clear = 1'b0;
      inc_n(9998);
      chk("s9998_score", {16'd0, score_bl}, 32'h9998);
      chk("s9998_sat", {31'd0, sat_bl}, 32'd0);
      inc_n(1);
      chk("s9999_score", {16'd0, score_bl}, 32'h9999);
      chk("s9999_sat", {31'd0, sat_bl}, 32'd1);
      inc_n(3);
      chk("sat_hold_score", {16'd0, score_nb}, 32'h9999);
      chk("sat_hold_sat", {31'd0, sat_nb}, 32'd1);
      inc = 1'b1; clear = 1'b1; tick(); inc = 1'b0; clear = 1'b0;
      chk("clr_inc_score", {16'd0, score_bl}, 32'h0000);
      chk("clr_inc_sat", {31'd0, sat_bl}, 32'd0);

      // Freeze blocks inc, scan keeps running.
      inc_n(1);
      chk("frz_pre", {16'd0, score_bl}, 32'h0001);
      freeze = 1'b1;
      an_before = anode_nb;
      for (int p = 0; p < 5; p++) begin
         inc = 1'b1; tick(); inc = 1'b0; tick();
         if (p == 1) chk("frz_scan_moves", {31'd0, (anode_nb != an_before)}, 32'd1);
      end
      chk("frz_score", {16'd0, score_bl}, 32'h0001);
      freeze = 1'b0;
      inc_n(1);
      chk("unfrz_score", {16'd0, score_bl}, 32'h0002);

      // Asynchronous reset in the middle of slot 2 at score 0123.
      clear = 1'b1; tick(); clear = 1'b0;
      inc_n(123);
      chk("s123_score", {16'd0, score_bl}, 32'h0123);
      wait_nb_anode(4'b1011, "s123_align");
      chk_slot("s123_slot2", 4'b1011, 4'd1, 4'b1011, 4'd1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_score", {16'd0, score_bl}, 32'h0000);
      chk("arst_sat", {31'd0, sat_bl}, 32'd0);
      chk("arst_anode", {28'd0, anode_bl}, 32'hE);
      chk("arst_digit", {28'd0, digit_bl}, 32'h0);
      tick();
      chk("arst_held_anode", {28'd0, anode_nb}, 32'hE);
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n <= 4; n++) begin
         chk($sformatf("rel_%0d", n), {28'd0, anode_nb}, (n < 4) ? 32'hE : 32'hD);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
